// File: rtl/logic_unit_pkg.sv
// Shared types and helpers for the pipelined bitwise logic unit.
// Optional flag output is enabled by defining LOGIC_UNIT_FLAGS_EN.
package logic_unit_pkg;

    typedef enum logic [1:0] {
        LU_AND = 2'b00,
        LU_OR  = 2'b01,
        LU_XOR = 2'b10,
        LU_NOR = 2'b11
    } lu_op_t;

    // Bit positions inside the 2-bit flag word {parity, zero}
    localparam int LU_FLAG_ZERO = 0;
    localparam int LU_FLAG_PAR  = 1;
    localparam int LU_FLAG_W    = 2;

    // Per-bit operation; the top applies it across every operand bit, which
    // keeps the function width-independent and NOR naturally confined to WIDTH.
    function automatic logic lu_eval(lu_op_t op, logic a, logic b);
        logic r;
        r = 1'b0;
        case (op)
            LU_AND:  r = a & b;
            LU_OR:   r = a | b;
            LU_XOR:  r = a ^ b;
            LU_NOR:  r = ~(a | b);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/logic_unit_if.sv
// Handshake bundle for logic_unit: input beat channel and result channel.
// out_flags exists only when LOGIC_UNIT_FLAGS_EN is defined.
interface logic_unit_if #(
    parameter int WIDTH = 32
);
    import logic_unit_pkg::*;

    logic             in_valid;
    logic             in_ready;
    lu_op_t           in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_res;
`ifdef LOGIC_UNIT_FLAGS_EN
    logic [LU_FLAG_W-1:0] out_flags;

    modport master (
        output in_valid, in_op, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_res, out_flags
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, out_ready,
        output in_ready, out_valid, out_res, out_flags
    );
`else
    modport master (
        output in_valid, in_op, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_res
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, out_ready,
        output in_ready, out_valid, out_res
    );
`endif

endinterface

// File: rtl/logic_unit_slot.sv
// One pipeline register slot: valid bit, payload, and its advance condition.
// An empty slot always advances, which lets bubbles collapse under stall.
module logic_unit_slot #(
    parameter int PW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          up_valid,
    input  logic [PW-1:0] up_data,
    input  logic          down_adv,
    output logic          valid,
    output logic [PW-1:0] data,
    output logic          adv
);

    logic          valid_q, valid_d;
    logic [PW-1:0] data_q, data_d;

    assign adv   = ~valid_q | down_adv;
    assign valid = valid_q;
    assign data  = data_q;

    // Load from upstream when advancing; payload is held when the beat is a bubble
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (adv) begin
            valid_d = up_valid;
            if (up_valid) begin
                data_d = up_data;
            end
        end
    end

    // Slot state register with synchronous flush
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/logic_unit.sv
// Pipelined bitwise logic unit (AND/OR/XOR/NOR) with valid/ready handshake
// and a wrapping delivered-result counter. Define LOGIC_UNIT_FLAGS_EN to
// carry {parity, zero} flags alongside each result.
module logic_unit
    import logic_unit_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    logic_unit_if.slave      bus,
    output logic [CNT_W-1:0] op_count
);

`ifdef LOGIC_UNIT_FLAGS_EN
    localparam int PW = WIDTH + LU_FLAG_W;
`else
    localparam int PW = WIDTH;
`endif

    logic [WIDTH-1:0]  res_in;
    logic [PW-1:0]     payload_in;
    logic [STAGES-1:0] slot_valid;
    logic [STAGES-1:0] slot_adv;
    logic [PW-1:0]     slot_data [STAGES];
    logic              deliver;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // Bitwise operation applied independently to every operand bit
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        assign res_in[gi] = lu_eval(bus.in_op, bus.in_a[gi], bus.in_b[gi]);
    end

`ifdef LOGIC_UNIT_FLAGS_EN
    logic [LU_FLAG_W-1:0] flags_in;
    always_comb begin
        flags_in               = '0;
        flags_in[LU_FLAG_ZERO] = ~|res_in;
        flags_in[LU_FLAG_PAR]  = ^res_in;
    end
    assign payload_in = {flags_in, res_in};
`else
    assign payload_in = res_in;
`endif

    // Chain of slots: slot 0 is fed by the input port, the last drives the output
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_slot
        logic          up_v;
        logic [PW-1:0] up_d;
        logic          dn_adv;

        if (gi == 0) begin : g_first
            assign up_v = bus.in_valid;
            assign up_d = payload_in;
        end else begin : g_mid
            assign up_v = slot_valid[gi-1];
            assign up_d = slot_data[gi-1];
        end

        if (gi == STAGES - 1) begin : g_last
            assign dn_adv = bus.out_ready;
        end else begin : g_inner
            assign dn_adv = slot_adv[gi+1];
        end

        logic_unit_slot #(.PW(PW)) u_slot (
            .clk      (clk),
            .rst      (rst),
            .up_valid (up_v),
            .up_data  (up_d),
            .down_adv (dn_adv),
            .valid    (slot_valid[gi]),
            .data     (slot_data[gi]),
            .adv      (slot_adv[gi])
        );
    end

    // Ready is forced high in reset; the slots ignore the beat because they flush
    assign bus.in_ready  = rst | slot_adv[0];
    assign bus.out_valid = slot_valid[STAGES-1];
    assign bus.out_res   = slot_data[STAGES-1][WIDTH-1:0];
`ifdef LOGIC_UNIT_FLAGS_EN
    assign bus.out_flags = slot_data[STAGES-1][WIDTH +: LU_FLAG_W];
`endif

    assign deliver  = slot_valid[STAGES-1] & bus.out_ready;
    assign op_count = cnt_q;

    // Delivered-result counter, wraps naturally at 2^CNT_W
    always_comb begin
        cnt_d = cnt_q;
        if (deliver) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: doc/logic_unit.md
# logic_unit

Parametrised, pipelined bitwise logic unit for the MIPS datapath. It replaces the fixed 32-bit gate-level AND and OR arrays with one block that has four selectable operations, configurable width and pipeline depth, and a valid/ready handshake. It sits between the register-read stage and writeback-result muxing. An optional flag output reports zero and parity of each result.

## Interface
Parameters:
- `WIDTH`, default 32: operand and result width in bits; legal range ≥ 1.
- `STAGES`, default 2: number of pipeline register slots; legal range ≥ 1.
- `CNT_W`, default 16: width of the completed-operation counter.

Ports:
- `clk`  in  1: the only clock; all state updates on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `in_valid`  in  1: input beat present.
- `in_ready`  out  1: block accepts the input beat this cycle.
- `in_op`  in  2: operation select. 00 AND, 01 OR, 10 XOR, 11 NOR.
- `in_a`, `in_b`  in  WIDTH: operands.
- `out_valid`  out  1: result present.
- `out_ready`  in  1: downstream accepts the result.
- `out_res`  out  WIDTH: result.
- `out_flags`  out  2: {parity, zero}. Present only under `LOGIC_UNIT_FLAGS_EN`.
- `op_count`  out  CNT_W: number of results delivered since reset.

## Operation
- An input beat is accepted when `in_valid && in_ready`. The result `f(op, a, b)` is computed combinationally and written into slot 0.
- Slots 0 to STAGES-1 each hold `{valid, res[, flags]}`. Slot STAGES-1 drives the outputs.
- Slot k advances when it is empty or slot k+1 advances. The last slot advances when it is empty or `out_ready` is high.
- Bubbles collapse: an empty slot loads from the slot before it even while downstream stalls.
- `in_ready` equals the advance condition of slot 0. It is combinational from `out_ready` and the valid bits, and never depends on `in_valid`.
- A delivered result is `out_valid && out_ready`. Each delivery increments `op_count` by 1. The counter wraps from 2^CNT_W-1 to 0.
- NOR is `~(a|b)`, masked to WIDTH bits.
- Results retain strict input order. Nothing is dropped or duplicated.
- While `out_valid=1` and `out_ready=0`, `out_res` and `out_flags` stay stable.

## Timing
- Latency is STAGES cycles from acceptance to `out_valid` when there is no back-pressure.
- Throughput is one result per cycle while `out_ready=1`.
- Reset values: all slot valid bits 0, `out_valid=0`, `out_res=0`, `out_flags=0`, `op_count=0`. During reset, `in_ready=1`, but no beat is captured.
- Reset mid-operation flushes all in-flight beats. Nothing is delivered in the cycle after reset deasserts.
- Pipeline full with `out_ready=0`: `in_ready=0`. Capacity is exactly STAGES beats.
- Full pipeline with `out_ready=1` and `in_valid=1` in the same cycle: one result leaves and one beat enters, so occupancy is unchanged.
- Simultaneous delivery and counter wrap: `op_count` reads 0 on the next cycle.

## Configuration
- `LOGIC_UNIT_FLAGS_EN` defined:
  - each slot stores `zero = (res == 0)` and `parity = ^res`, computed at slot 0;
  - `out_flags` exists and travels aligned with `out_res`.
- Undefined: no flag storage, and the `out_flags` port is absent. All other behaviour is identical.

## Structure
- Shared package `logic_unit_pkg`:
  - 2-bit op enum `lu_op_t` (`LU_AND`, `LU_OR`, `LU_XOR`, `LU_NOR`);
  - flag bit index constants `LU_FLAG_ZERO=0`, `LU_FLAG_PAR=1`.
- Sub-module `logic_unit_slot`: one pipeline register slot holding valid, payload, and the advance logic. It is instantiated STAGES times in a generate loop.
- The combinational op function lives in the package as `lu_eval(op, a, b)`.

## Test plan
- Reset, then stream all four ops with a=0xF0F0_1234 and b=0x0FF0_FFFF, `out_ready=1`, STAGES=2:
  - expected results in order 0x00F0_1234, 0xFFF0_FFFF, 0xFF00_EDCB, 0x000F_0000;
  - each result appears 2 cycles after acceptance;
  - `op_count` reaches 4.
- Flags (macro on): AND of 0x0 and 0xFFFF_FFFF gives result 0 with flags 2'b01. XOR of 0x1 and 0x0 gives 2'b10.
- Back-pressure: hold `out_ready=0`.
  - After 2 accepts, `in_ready=0`.
  - `out_res` holds its value for 5 cycles.
  - Release `out_ready`: both results are delivered in order on consecutive cycles.
- Bubble collapse, STAGES=3: issue 1 beat, wait 1 cycle, issue a 2nd beat, with `out_ready=0`. Both beats pack into the last two slots and `in_ready` stays 1.
- Reset mid-stream with 2 beats in flight: `out_valid` stays 0 afterwards and `op_count=0`. A new beat is delivered with normal latency.
- Wrap, CNT_W=4: after 16 deliveries `op_count=0`. WIDTH=8 with NOR of 0x0F and 0x30 gives 0xC0.
